uart_tx_sequencer: RTL
======================

Name: uart_tx_sequencer

Overview:
Consumes a latched transmit command (start pulse, seed byte, byte count, inter-byte delay code) and drives a byte-wide UART transmitter over a start/done handshake. It emits a burst of N bytes, with an optional timed gap after each byte, and reports progress and completion. It sits between the button/command latch stage and the UART TX serializer.

Parameters:
TICK_HZ, 3200, rate of the CE enable strobe in Hz; the base for all gap timing.
MAX_BYTES, 256, largest legal byte count; bytes_to_send above this is clamped to MAX_BYTES.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
CE  input  1  timing enable strobe at TICK_HZ; gap counter advances only when CE=1
start  input  1  one-cycle command pulse; sampled only in IDLE
data  input  8  seed byte of the burst
bytes_to_send  input  15  number of bytes in the burst
delay  input  2  gap code: 0=none, 1=TICK_HZ/2 ticks, 2=TICK_HZ ticks, 3=2*TICK_HZ ticks
tx_done  input  1  one-cycle pulse from the serializer when the current byte has finished
tx_start  output  1  one-cycle request to the serializer
tx_data  output  8  byte to send; held stable from tx_start until tx_done
busy  output  1  high from the accepted start until done
done  output  1  one-cycle pulse when the burst completes
bytes_sent  output  15  count of bytes acknowledged in the current or last burst

Behaviour:
- Reset (asynchronous, active-high): state=IDLE; tx_start=0, tx_data=0, busy=0, done=0, bytes_sent=0; internal counters cleared. Reset mid-burst aborts the burst immediately, with no done pulse.
- Clock-edge updates happen every clk cycle, not gated by CE. CE gates only gap-tick counting.
- States:
  - IDLE: on start=1, capture data, bytes_to_send (clamped) and delay into internal registers; clear bytes_sent; set busy=1; go to LOAD. start pulses in any other state are ignored and do not queue.
  - LOAD: if the captured count is 0, go to FINISH. Otherwise set tx_data = seed + bytes_sent (mod 256) and go to SEND.
  - SEND: assert tx_start for exactly one cycle, then go to WAIT_TX.
  - WAIT_TX: hold tx_data. On tx_done, increment bytes_sent. If bytes_sent+1 equals the count, go to FINISH. Otherwise go to GAP if delay≠0, else go to LOAD.
  - GAP: clear the tick counter on entry and increment it on each CE=1 cycle. When it reaches the gap length for the captured delay code, go to LOAD. CE=1 on the entry cycle does count.
  - FINISH: pulse done=1 for one cycle, drop busy, return to IDLE. bytes_sent holds its final value until the next accepted start.
- Latency:
  - start to tx_start: 2 clk cycles (IDLE→LOAD→SEND).
  - tx_done to the next tx_start with delay=0: 2 cycles.
- Payload: byte k (0-based) = data + k, truncated to 8 bits, so it wraps 0xFF→0x00.
- Last byte gets no trailing gap: FINISH follows tx_done directly.
- tx_done arriving outside WAIT_TX is ignored.
- start and tx_done in the same cycle: each is interpreted only in its own state, so there is no conflict.
- Inputs data, delay and bytes_to_send may change mid-burst with no effect, because only the captured copies are used.
- Counter widths: the gap counter is sized by $clog2(2*TICK_HZ+1); bytes_sent is 15 bits.

Decomposition:
- Package uart_tx_seq_pkg holds:
  - the state enum type (IDLE, LOAD, SEND, WAIT_TX, GAP, FINISH);
  - a function mapping the 2-bit delay code to a gap length in ticks from TICK_HZ.
- One natural sub-module, gap_timer: a CE-gated down-counter with load, length and expired signals. Everything else stays in the top FSM.

Test Plan:
- TICK_HZ=8, data=0x41, bytes_to_send=3, delay=0, bench answers tx_done 10 cycles after each tx_start -> tx_data 0x41, 0x42, 0x43; one tx_start per byte; done pulses once; bytes_sent=3; busy drops the same cycle done asserts.
- data=0xFE, bytes_to_send=4, delay=0 -> payload 0xFE, 0xFF, 0x00, 0x01 (wrap-around).
- TICK_HZ=8, delay=2, CE every 4th clk, bytes_to_send=2 -> exactly 8 CE ticks between the first tx_done and the second tx_start's LOAD; no gap after the last byte.
- bytes_to_send=0, start -> no tx_start ever; done pulses 2 cycles after start; bytes_sent=0.
- Second start pulse plus changed data/delay mid-burst -> ignored; the burst continues with the captured values; exactly one done.
- Assert reset during GAP of a 32-byte burst -> all outputs 0 immediately; no done; a fresh start afterwards runs a clean full burst from the new seed.

Source files
------------

// File: rtl/uart_tx_sequencer_pkg.sv
// Shared types and helpers for the UART TX burst sequencer.
package uart_tx_seq_pkg;

  // Sequencer FSM states; exposed on the debug port of the top.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    SEND    = 3'd2,
    WAIT_TX = 3'd3,
    GAP     = 3'd4,
    FINISH  = 3'd5
  } state_t;

  // Gap length in CE ticks for a delay code, scaled from the tick rate.
  function automatic int gap_ticks(input logic [1:0] code, input int tick_hz);
    int len;
    case (code)
      2'd0:    len = 0;
      2'd1:    len = tick_hz / 2;
      2'd2:    len = tick_hz;
      default: len = 2 * tick_hz;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/uart_tx_sequencer_if.sv
// Byte-wide handshake between the sequencer and the UART TX serializer.
//
// Handshake: the master raises tx_start for exactly one cycle with tx_data
// valid, and keeps tx_data stable until the slave answers with a one-cycle
// tx_done. The master issues no new tx_start before that tx_done. A tx_done
// that arrives while no byte is outstanding has no effect.
interface uart_tx_if;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_done;

  modport master (output tx_start, output tx_data, input tx_done);
  modport slave  (input tx_start, input tx_data, output tx_done);
endinterface

// File: rtl/uart_tx_sequencer_gap_timer.sv
// CE-gated down-counter that times the inter-byte gap.
module gap_timer #(
  parameter int CW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_load,
  input  logic          i_run,
  input  logic          i_ce,
  input  logic [CW-1:0] i_len,
  output logic          o_expired
);

  logic [CW-1:0] r_cnt;

  // Load the gap length on entry, then count down one step per CE tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_len;
    end else if (i_run && i_ce && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  // Expiry fires on the tick that consumes the last remaining count, so
  // the FSM leaves the gap on the same cycle as the final CE.
  assign o_expired = i_run && i_ce && (r_cnt == CW'(1));

endmodule

// File: rtl/uart_tx_sequencer.sv
// Burst sequencer: sends N bytes (seed, seed+1, ...) to the UART serializer,
// with an optional CE-timed gap after every byte except the last.
module uart_tx_sequencer
  import uart_tx_seq_pkg::*;
#(
  parameter int TICK_HZ   = 3200,
  parameter int MAX_BYTES = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        CE,
  input  logic        start,
  input  logic [7:0]  data,
  input  logic [14:0] bytes_to_send,
  input  logic [1:0]  delay,
  uart_tx_if.master   tx,
  output logic        busy,
  output logic        done,
  output logic [14:0] bytes_sent,
  output state_t      state_dbg
);

  localparam int CW = $clog2(2 * TICK_HZ + 1);

  state_t        r_state;
  state_t        w_next;
  logic [7:0]    r_seed;
  logic [14:0]   r_count;
  logic [1:0]    r_delay;
  logic [7:0]    r_tx_data;
  logic [14:0]   r_bytes_sent;
  logic [14:0]   w_count_in;
  logic          w_last;
  logic          w_gap_load;
  logic          w_gap_run;
  logic          w_gap_expired;
  logic [CW-1:0] w_gap_len;

  assign w_count_in = (bytes_to_send > 15'(MAX_BYTES)) ? 15'(MAX_BYTES) : bytes_to_send;
  assign w_last     = ((r_bytes_sent + 15'd1) == r_count);
  assign w_gap_len  = CW'(gap_ticks(r_delay, TICK_HZ));
  assign w_gap_load = (r_state == WAIT_TX) && tx.tx_done && !w_last && (r_delay != 2'd0);
  assign w_gap_run  = (r_state == GAP);

  gap_timer #(.CW(CW)) u_gap_timer (
    .clk       (clk),
    .reset     (reset),
    .i_load    (w_gap_load),
    .i_run     (w_gap_run),
    .i_ce      (CE),
    .i_len     (w_gap_len),
    .o_expired (w_gap_expired)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; start and tx_done are only looked at in their own states.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = LOAD;
      LOAD:    w_next = (r_count == 15'd0) ? FINISH : SEND;
      SEND:    w_next = WAIT_TX;
      WAIT_TX: begin
        if (tx.tx_done) begin
          if (w_last)                  w_next = FINISH;
          else if (r_delay != 2'd0)    w_next = GAP;
          else                         w_next = LOAD;
        end
      end
      GAP:     if (w_gap_expired) w_next = LOAD;
      FINISH:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Command capture, payload generation and progress counting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_seed       <= '0;
      r_count      <= '0;
      r_delay      <= '0;
      r_tx_data    <= '0;
      r_bytes_sent <= '0;
    end else begin
      if ((r_state == IDLE) && start) begin
        r_seed       <= data;
        r_count      <= w_count_in;
        r_delay      <= delay;
        r_bytes_sent <= '0;
      end
      if ((r_state == LOAD) && (r_count != 15'd0)) begin
        r_tx_data <= r_seed + r_bytes_sent[7:0];
      end
      if ((r_state == WAIT_TX) && tx.tx_done) begin
        r_bytes_sent <= r_bytes_sent + 15'd1;
      end
    end
  end

  assign tx.tx_start = (r_state == SEND);
  assign tx.tx_data  = r_tx_data;
  assign busy        = (r_state inside {LOAD, SEND, WAIT_TX, GAP});
  assign done        = (r_state == FINISH);
  assign bytes_sent  = r_bytes_sent;
  assign state_dbg   = r_state;

endmodule
